// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    // Widest request address the index helper accepts; callers zero-extend.
    localparam int unsigned MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    // Word index of a byte address; depth must be a power of two.
    function automatic int unsigned word_index(input logic [MAX_ADDR_W-1:0] addr,
                                               input int unsigned depth);
        return 32'(addr[33:2]) & (depth - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 RAM with byte-lane writes and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write enabled lanes, read the addressed word every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// performs the access and holds the response until the CPU takes it.
// Optional macro DMEM_BOUNDS_CHECK_EN: addresses >= DEPTH*4 respond with rsp_err=1,
// rdata 0 and no write; otherwise rsp_err stays 0 and addresses wrap.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              alive_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Latched request (datapath only, no reset needed).
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              oob_q;
    logic              in_access_q;

    logic              accept;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ram_idx;
    logic              req_oob;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready = alive_q && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign req_idx   = IDX_W'(word_index(MAX_ADDR_W'(req_addr), DEPTH));

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oob = ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH * 4));
`else
    assign req_oob = 1'b0;
`endif

    // Read the incoming address on the accept edge so data is ready by ACCESS even
    // with zero wait states.
    assign ram_idx = (state_q == StIdle) ? req_idx : idx_q;

    // The access flag is not reset, so a store already in ACCESS still commits
    // if reset arrives during that cycle.
    assign ram_we = in_access_q && we_q && !oob_q;

    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Next-state, wait counter and response register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                state_d = StResp;
                rdata_d = (we_q || oob_q) ? '0 : ram_rdata;
                err_d   = oob_q;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            alive_q <= 1'b1;
        end
    end

    // Capture the request on accept and track the ACCESS cycle for the RAM write.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            oob_q   <= req_oob;
        end
        in_access_q <= (state_d == StAccess);
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .wstrb (wstrb_q),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 0 and 15 (DEPTH 256).
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [31:0] model [3][256];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          lat;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(32)) u_l2 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0), .ADDR_W(32)) u_l0 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(15), .ADDR_W(32)) u_l15 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_wstrb(req_wstrb[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int k);
        for (int i = 0; i < 50 && !req_ready[k]; i++) @(negedge clk);
        if (!req_ready[k]) check_eq("req_ready wait", 32'(req_ready[k]), 32'd1);
    endtask

    // One transaction: push expectation, drive, wait for response, compare, handshake.
    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int stall,
                       input bit pulse, output int lat_o);
        exp_t        e;
        int          idx;
        logic        oob;
        int          cyc;
        logic [31:0] held;
        idx = int'(addr[9:2]);
        oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        oob = (addr >= 32'h400);
`endif
        e.err   = oob;
        e.rdata = (we || oob) ? 32'h0 : model[k][idx];
        if (we && !oob) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[k][idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        sb.push_back(e);

        wait_ready(k);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_wstrb[k] = strb;
        rsp_ready[k] = (stall == 0);
        @(negedge clk);
        check_eq("busy after accept", 32'(req_ready[k]), 32'd0);
        // Scramble request inputs; the DUT must use its latched copy.
        req_valid[k] = pulse;
        req_we[k]    = ~we;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_wstrb[k] = 4'hF;
        cyc = 1;
        while (!rsp_valid[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req_valid[k] = 1'b0;
        end
        req_valid[k] = 1'b0;
        lat_o = cyc;
        e = sb.pop_front();
        if (!rsp_valid[k]) begin
            check_eq("rsp_valid timeout", 32'(rsp_valid[k]), 32'd1);
        end else begin
            check_eq("rsp_rdata", rsp_rdata[k], e.rdata);
            check_eq("rsp_err", 32'(rsp_err[k]), 32'(e.err));
            held = rsp_rdata[k];
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check_eq("held rsp_valid", 32'(rsp_valid[k]), 32'd1);
                check_eq("held rsp_rdata", rsp_rdata[k], held);
                check_eq("held req_ready", 32'(req_ready[k]), 32'd0);
            end
            rsp_ready[k] = 1'b1;
            @(negedge clk);
            check_eq("post-hs rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check_eq("post-hs rsp_rdata", rsp_rdata[k], 32'h0);
            check_eq("post-hs req_ready", 32'(req_ready[k]), 32'd1);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid[k];
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
            req_wstrb[k] = 4'h0;
            rsp_ready[k] = 1'b0;
            for (int i = 0; i < 256; i++) model[k][i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("reset req_ready", 32'(req_ready[k]), 32'd0);
            check_eq("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check_eq("reset rsp_rdata", rsp_rdata[k], 32'h0);
            check_eq("reset rsp_err", 32'(rsp_err[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_eq("ready after reset", 32'(req_ready[k]), 32'd1);

        // LATENCY=2: full store, latency, read-back.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat);
        check_eq("lat2 store latency", 32'(lat), 32'd4);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat);
        check_eq("lat2 load latency", 32'(lat), 32'd4);

        // Partial and empty strobes.
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, lat);
        txn(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 0, 1'b0, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, lat);
        txn(0, 1'b1, 32'h23, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, lat);
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, lat);

        // Back-pressure for five cycles.
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, lat);

        // Address range: wraps without bounds checking, errors with it.
        txn(0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 0, 1'b0, lat);
        txn(0, 1'b1, 32'h4, 32'h04040404, 4'hF, 0, 1'b0, lat);
        txn(0, 1'b1, 32'h404, 32'hCAFEF00D, 4'hF, 0, 1'b0, lat);
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, lat);
        txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0, lat);

        // Reset during WAIT aborts a store.
        txn(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 0, 1'b0, lat);
        wait_ready(0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'h00000055;
        req_wstrb[0] = 4'hF;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("mid-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
            check_eq("mid-reset req_ready", 32'(req_ready[0]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready after mid-reset", 32'(req_ready[0]), 32'd1);
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, lat);

        // LATENCY=0 and LATENCY=15, with req_valid pulsed while busy.
        txn(1, 1'b1, 32'h8, 32'h01020304, 4'hF, 0, 1'b0, lat);
        check_eq("lat0 store latency", 32'(lat), 32'd2);
        txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, lat);
        check_eq("lat0 load latency", 32'(lat), 32'd2);
        check_quiet(1, "lat0 no second rsp");

        txn(2, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, 0, 1'b0, lat);
        check_eq("lat15 store latency", 32'(lat), 32'd17);
        txn(2, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, lat);
        check_eq("lat15 load latency", 32'(lat), 32'd17);
        check_quiet(2, "lat15 no second rsp");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
